// File: rtl/operand_stack.sv
// Operand stack: TOS/NOS held in registers, deeper entries spill to a synchronous-read array.
// Optional STACK_BUS_DRIVE_EN adds a tri-stated copy of tos (bus_oe / bus_out) for a shared data bus.
//
// state  | meaning
// IDLE   | accepting ops
// REFILL | one-cycle reload of nos from the spill array after POP/BINOP at count>=3
module operand_stack #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        op,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [WIDTH-1:0]  din,
  input  logic              clr_err,
`ifdef STACK_BUS_DRIVE_EN
  input  logic              bus_oe,
  output logic [WIDTH-1:0]  bus_out,
`endif
  output logic [WIDTH-1:0]  tos,
  output logic [WIDTH-1:0]  nos,
  output logic [ADDR_W:0]   count,
  output logic [3:0]        flags
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_BINOP = 2'b11;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_data;
  logic [ADDR_W-1:0] sp;
  logic              full, empty, ovf, unf;
  logic              accept, push_ok, pop_ok, bin_ok, refill_go, ovf_err, unf_err;
  logic              ge2, ge3;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign ge2   = (count >= CNT_W'(2));
  assign ge3   = (count >= CNT_W'(3));
  // Modulo arithmetic on the low bits gives DEPTH-2 when count==DEPTH.
  assign sp    = ge2 ? (count[ADDR_W-1:0] - ADDR_W'(2)) : '0;
  assign flags = {ovf, unf, full, empty};

`ifdef STACK_BUS_DRIVE_EN
  assign bus_out = bus_oe ? tos : {WIDTH{1'bz}};
`endif

  always_comb begin
    op_ready  = (state == IDLE);
    accept    = op_valid & op_ready & reset;
    push_ok   = accept & (op == OP_PUSH) & ~full;
    ovf_err   = accept & (op == OP_PUSH) & full;
    pop_ok    = accept & (op == OP_POP) & ~empty;
    bin_ok    = accept & (op == OP_BINOP) & ge2;
    unf_err   = accept & (((op == OP_POP) & empty) | ((op == OP_BINOP) & ~ge2));
    refill_go = (pop_ok | bin_ok) & ge3;
    state_nx  = state;
    case (state)
      IDLE:    if (refill_go) state_nx = REFILL;
      REFILL:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tos   <= '0;
      nos   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (push_ok) begin
        nos   <= tos;
        tos   <= din;
        count <= count + CNT_W'(1);
      end else if (pop_ok) begin
        tos   <= nos;
        count <= count - CNT_W'(1);
      end else if (bin_ok) begin
        tos   <= din;
        count <= count - CNT_W'(1);
      end
      if (state == REFILL) nos <= rd_data;
      ovf <= ovf_err | (ovf & ~clr_err);
      unf <= unf_err | (unf & ~clr_err);
    end
  end

  // Spill storage is not reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push_ok && ge2) mem[sp] <= nos;
    if (refill_go) rd_data <= mem[sp - ADDR_W'(1)];
  end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
Hardware operand stack for the stack CPU, directly upstream of the 16-bit register and flag stage.
- Holds the top two entries (TOS, NOS) in registers so the ALU sees both operands combinationally.
- Deeper entries spill into an internal synchronous-read array.
- Drives the operand bus feeding the R_16 registers and a 4-bit status word consumed by Flag_Reg.

Parameters:
WIDTH, 16, data width of each entry
DEPTH, 16, total capacity including TOS and NOS (must be at least 4)
ADDR_W, 4, spill-array address width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
op  in  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 BINOP (replace TOS and NOS by din)
op_valid  in  1  op/din qualifier
op_ready  out  1  high when the block can accept an op this cycle
din  in  WIDTH  push / BINOP result data
clr_err  in  1  clears sticky error flags
tos  out  WIDTH  top of stack
nos  out  WIDTH  next on stack
count  out  ADDR_W+1  number of valid entries, 0..DEPTH
flags  out  4  {ovf, unf, full, empty}

Behaviour:
- Reset (reset==0 at a clk edge):
  - tos, nos, count = 0; ovf, unf = 0; state = IDLE; op_ready = 1.
  - Reset mid-REFILL aborts the refill and overrides all ops.
- An op is accepted when op_valid & op_ready. NOP or op_valid=0 leaves all state unchanged.
- full = (count==DEPTH), empty = (count==0), both combinational from count. ovf and unf are sticky.
- Spill pointer sp = count-2 when count>=2, else 0. The spill array holds entries 0..sp-1.
- PUSH:
  - If full: no state change, ovf set next cycle.
  - Else, single cycle: if count>=2 then mem[sp] <= nos; nos <= tos; tos <= din; count+1.
- POP:
  - If count==0: unf set, no change.
  - Else: tos <= nos; count-1.
  - If count>=3 before the op: read address sp-1 is issued, state -> REFILL.
  - If count==1 before the op, nos is don't-care and is held at its old value.
- BINOP:
  - If count<2: unf set, no change.
  - Else: tos <= din; count-1.
  - If count>=3 before the op: state -> REFILL. Otherwise nos is held.
- REFILL state (exactly 1 cycle):
  - op_ready = 0; nos <= array read data; state -> IDLE.
  - Ops presented during REFILL are not accepted. The master holds op_valid.
- Latency: PUSH and non-refilling POP/BINOP complete in 1 cycle. POP/BINOP with count>=3 occupy 2 cycles; the new tos is visible after 1 cycle, the new nos after 2.
- Sticky error flags:
  - If clr_err and a new error occur in the same cycle, the error wins (flag set).
  - clr_err has no effect on tos, nos or count.
- Arithmetic: count is unsigned and never wraps. Illegal ops at the boundaries are blocked before any update.
- A PUSH at count==DEPTH-1 is legal and produces full=1.

Optional Feature:
STACK_BUS_DRIVE_EN
- Defined: adds ports bus_oe (in, 1) and bus_out (out, WIDTH). bus_out = tos when bus_oe=1, else all-Z (16'hZZZZ at default width), so the stack can share the CPU data bus with TransferSwitch-driven sources.
- Undefined: neither port exists. tos is the only data output.

Test Plan:
1. Reset low for 2 cycles, then high -> tos=0, nos=0, count=0, flags=4'b0001, op_ready=1.
2. PUSH 0x1111, 0x2222, 0x3333 on back-to-back cycles -> tos=0x3333, nos=0x2222, count=3, op_ready stays 1.
3. From test 2, POP -> next cycle tos=0x2222 with op_ready=0; following cycle nos=0x1111 with op_ready=1; count=2.
4. BINOP din=0xAAAA at count=2 -> tos=0xAAAA, count=1, no REFILL. Then BINOP -> unf=1, flags=4'b0100, state unchanged. Then clr_err -> flags=4'b0000.
5. Push DEPTH=16 values 0x0001..0x0010 -> full=1, count=16. A 17th PUSH -> ovf=1, tos=0x0010. Then 15 POPs -> each value returned in LIFO order, final count=1, tos=0x0001.
6. Assert reset low during REFILL -> next cycle count=0, op_ready=1, no residual nos update. With STACK_BUS_DRIVE_EN: bus_oe=0 -> bus_out=Z; bus_oe=1 -> bus_out=tos.
